// File: rtl/ch8_fetch_unit.sv
// CHIP-8 style instruction fetch unit: reads a 2-byte opcode from synchronous byte RAM,
// presents it to the decoder with a valid/ready handshake, and resolves jump/call/return/skip.
module ch8_fetch_unit #(
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] START_ADDR  = 'h200,
  parameter int                STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [15:0]       ins_opcode,
  output logic [ADDR_W-1:0] ins_pc,
  output logic [3:0]        op_x,
  output logic [3:0]        op_y,
  output logic [3:0]        op_n,
  output logic [7:0]        op_nn,
  output logic [11:0]       op_nnn,
  input  logic              ctl_jump,
  input  logic              ctl_call,
  input  logic              ctl_ret,
  input  logic              ctl_skip,
  input  logic [ADDR_W-1:0] ctl_addr,
  output logic              stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  // One extra bit so sp can hold STACK_DEPTH (stack full).
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    CAPTURE,
    PRESENT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic              handshake;
  logic              push_en;

  assign handshake = (state == PRESENT) && ins_ready;
  assign sp_dec    = sp - SP_W'(1);
  // A call only pushes when no return outranks it, there is room, and reset is not aborting the cycle.
  assign push_en   = handshake && !reset && !ctl_ret && ctl_call && (sp != SP_FULL);

  assign op_x   = ins_opcode[11:8];
  assign op_y   = ins_opcode[7:4];
  assign op_n   = ins_opcode[3:0];
  assign op_nn  = ins_opcode[7:0];
  assign op_nnn = ins_opcode[11:0];

  // NOTE: the return-address RAM has no reset; only sp is cleared, which is enough to make old entries unreachable.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[sp[IDX_W-1:0]] <= pc;
  end

  // NOTE: every register here uses <= so all state updates see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= START_ADDR;
      sp         <= '0;
      stack_err  <= 1'b0;
      ins_valid  <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      hi_byte    <= '0;
      ins_opcode <= '0;
      ins_pc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (step_en) begin
            state    <= FETCH_HI;
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end
        end
        FETCH_HI: begin
          state    <= FETCH_LO;
          mem_addr <= pc + ADDR_W'(1);
        end
        FETCH_LO: begin
          hi_byte <= mem_rdata;
          mem_rd  <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          ins_opcode <= {hi_byte, mem_rdata};
          ins_pc     <= pc;
          pc         <= pc + ADDR_W'(2);
          ins_valid  <= 1'b1;
          state      <= PRESENT;
        end
        PRESENT: begin
          if (ins_ready) begin
            ins_valid <= 1'b0;
            state     <= IDLE;
            if (ctl_ret) begin
              if (sp != '0) begin
                sp <= sp_dec;
                pc <= stack_mem[sp_dec[IDX_W-1:0]];
              end else begin
                stack_err <= 1'b1;
              end
            end else if (ctl_call) begin
              if (sp != SP_FULL) begin
                sp <= sp + SP_W'(1);
                pc <= ctl_addr;
              end else begin
                stack_err <= 1'b1;
              end
            end else if (ctl_jump) begin
              pc <= ctl_addr;
            end else if (ctl_skip) begin
              pc <= pc + ADDR_W'(2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ch8_fetch_unit.sv
// Self-checking bench for ch8_fetch_unit: random RAM and flow control checked against
// a reference model that tracks the program counter and a return-address queue.
module tb_ch8_fetch_unit;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, step_en, mem_rd, ins_valid, ins_ready, stack_err;
  logic [11:0] mem_addr, ins_pc, ctl_addr, op_nnn;
  logic [7:0]  mem_rdata, op_nn;
  logic [15:0] ins_opcode;
  logic [3:0]  op_x, op_y, op_n;
  logic        ctl_jump, ctl_call, ctl_ret, ctl_skip;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ram [4096];
  logic [11:0] pc_m;
  logic [11:0] stk [$];
  bit          err_m;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  ch8_fetch_unit #(.ADDR_W(12), .START_ADDR(12'h200), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .step_en(step_en),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_opcode(ins_opcode), .ins_pc(ins_pc),
    .op_x(op_x), .op_y(op_y), .op_n(op_n), .op_nn(op_nn), .op_nnn(op_nnn),
    .ctl_jump(ctl_jump), .ctl_call(ctl_call), .ctl_ret(ctl_ret), .ctl_skip(ctl_skip),
    .ctl_addr(ctl_addr), .stack_err(stack_err)
  );

  task automatic model_reset();
    pc_m  = 12'h200;
    stk.delete();
    err_m = 1'b0;
  endtask

  task automatic noise(input bit rdy_ok);
    {ctl_ret, ctl_call, ctl_jump, ctl_skip} = 4'($urandom);
    ctl_addr  = 12'($urandom);
    ins_ready = rdy_ok ? 1'($urandom) : 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; step_en = 1'b0; ins_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One full instruction: fetch, present, optional stall, handshake with the given controls.
  task automatic do_instr(input bit r, input bit c, input bit j, input bit s,
                          input logic [11:0] a, input int stall, input bit abort);
    logic [11:0] p, p1, p2;
    logic [15:0] op;
    p  = pc_m;
    p1 = p + 12'd1;
    p2 = p + 12'd2;
    op = {ram[p], ram[p1]};
    @(negedge clk); step_en = 1'b1; noise(1'b1);
    @(negedge clk); step_en = 1'b0; noise(1'b1);
    n_tests++; if (mem_rd !== 1'b1 || mem_addr !== p) begin n_fail++; $display("FAIL fetch_hi: rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, p); end
    @(negedge clk); noise(1'b1);
    n_tests++; if (mem_rd !== 1'b1 || mem_addr !== p1) begin n_fail++; $display("FAIL fetch_lo: rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, p1); end
    @(negedge clk); noise(1'b0);
    n_tests++; if (mem_rd !== 1'b0 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL capture: rd=%b valid=%b want 0 0", mem_rd, ins_valid); end
    @(negedge clk); noise(1'b0);
    n_tests++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL latency: valid=%b want 1", ins_valid); do_reset(); return; end
    n_tests++; if (ins_opcode !== op || ins_pc !== p) begin n_fail++; $display("FAIL opcode: op=%h pc=%h want op=%h pc=%h", ins_opcode, ins_pc, op, p); end
    n_tests++;
    if (op_x !== 4'(op >> 8) || op_y !== 4'(op >> 4) || op_n !== 4'(op) || op_nn !== 8'(op) || op_nnn !== 12'(op)) begin
      n_fail++; $display("FAIL fields: x=%h y=%h n=%h nn=%h nnn=%h for op=%h", op_x, op_y, op_n, op_nn, op_nnn, op);
    end
    for (int i = 0; i < stall; i++) begin
      step_en = 1'($urandom);
      @(negedge clk); noise(1'b0); step_en = 1'b0;
      n_tests++;
      if (ins_valid !== 1'b1 || mem_rd !== 1'b0 || ins_opcode !== op || ins_pc !== p) begin
        n_fail++; $display("FAIL stall: valid=%b rd=%b op=%h pc=%h want 1 0 %h %h", ins_valid, mem_rd, ins_opcode, ins_pc, op, p);
      end
    end
    step_en = 1'b0; ins_ready = 1'b1; reset = abort;
    {ctl_ret, ctl_call, ctl_jump, ctl_skip} = {r, c, j, s};
    ctl_addr = a;
    @(negedge clk);
    ins_ready = 1'b0; reset = 1'b0;
    {ctl_ret, ctl_call, ctl_jump, ctl_skip} = 4'b0;
    if (abort) begin
      model_reset();
    end else begin
      pc_m = p2;
      if (r) begin
        if (stk.size() > 0) pc_m = stk.pop_back();
        else err_m = 1'b1;
      end else if (c) begin
        if (stk.size() < DEPTH) begin stk.push_back(pc_m); pc_m = a; end
        else err_m = 1'b1;
      end else if (j) pc_m = a;
      else if (s) pc_m = pc_m + 12'd2;
    end
    n_tests++;
    if (ins_valid !== 1'b0 || mem_rd !== 1'b0 || stack_err !== err_m) begin
      n_fail++; $display("FAIL handshake: valid=%b rd=%b err=%b want 0 0 %b", ins_valid, mem_rd, stack_err, err_m);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; step_en = 1'b1; ins_ready = 1'b1;
    ctl_call = 1'b1; ctl_addr = 12'h555;
    @(negedge clk);
    n_tests++;
    if (mem_rd !== 1'b0 || ins_valid !== 1'b0 || ins_opcode !== 16'h0 || ins_pc !== 12'h0 || stack_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: rd=%b valid=%b op=%h pc=%h err=%b want all 0", mem_rd, ins_valid, ins_opcode, ins_pc, stack_err);
    end
    n_tests++;
    if ({op_x, op_y, op_n, op_nn, op_nnn} !== 32'h0) begin
      n_fail++; $display("FAIL reset_fields: %h want 0", {op_x, op_y, op_n, op_nn, op_nnn});
    end
    reset = 1'b0; step_en = 1'b0; ins_ready = 1'b0; ctl_call = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    ram[12'h200] = 8'h12;
    ram[12'h201] = 8'h34;
    do_instr(0, 0, 0, 0, 12'h0, 0, 0);
  endtask

  task automatic test_stall();
    do_instr(0, 0, 0, 0, 12'h0, 5, 0);
  endtask

  task automatic test_call_ret();
    do_reset();
    do_instr(0, 1, 0, 0, 12'h300, 0, 0);
    do_instr(1, 0, 0, 0, 12'h0, 0, 0);
    do_instr(0, 0, 0, 0, 12'h0, 0, 0);
    do_instr(1, 0, 0, 0, 12'h0, 0, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= DEPTH; i++) do_instr(0, 1, 0, 0, 12'($urandom), 0, 0);
    do_instr(0, 0, 0, 0, 12'h0, 0, 0);
  endtask

  task automatic test_underflow();
    do_reset();
    do_instr(1, 0, 0, 0, 12'h0, 0, 0);
    do_instr(0, 0, 0, 0, 12'h0, 0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    do_instr(0, 0, 1, 0, 12'hFFE, 0, 0);
    do_instr(0, 0, 0, 1, 12'h0, 0, 0);
    do_instr(0, 0, 1, 0, 12'hFFF, 0, 0);
    do_instr(0, 0, 0, 0, 12'h0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_instr(0, 1, 0, 0, 12'h480, 0, 0);
    @(negedge clk); step_en = 1'b1;
    @(negedge clk); step_en = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    n_tests++; if (ins_valid !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_lo: valid=%b rd=%b want 0 0", ins_valid, mem_rd); end
    @(negedge clk);
    n_tests++; if (ins_valid !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_idle: valid=%b rd=%b want 0 0", ins_valid, mem_rd); end
    do_instr(0, 1, 0, 0, 12'h6A0, 2, 1);
    do_instr(1, 0, 0, 0, 12'h0, 0, 0);
    do_instr(0, 0, 0, 0, 12'h0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) @(negedge clk);
      do_instr(($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
               ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
               12'($urandom), int'($urandom_range(3, 0)), 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; step_en = 1'b0; ins_ready = 1'b0;
    {ctl_ret, ctl_call, ctl_jump, ctl_skip} = 4'b0;
    ctl_addr = 12'h0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
